mux4_rr_sched: RTL and testbench

Round-robin scheduler that shares one 4-to-1 bit multiplexer between four requesters. Each requester raises a request line; the block grants one requester at a time, drives the 2-bit mux select and a one-hot grant, and presents the selected data bit on `z`. A per-grant hold counter enforces fairness under contention. Sits between the switch/requester logic and the shared 4:1 mux datapath on the lab board design.

---
 rtl/mux4_rr_sched_if.sv | 13 +
 rtl/mux4_rr_sched.sv | 109 ++++++++++
 tb/tb_mux4_rr_sched.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mux4_rr_sched_if.sv
// Requester-side bundle for the shared 4:1 mux: request/data in, grant/select/output back.
// No flow control of its own; requesters hold req until they are done.
interface mux4_rr_sched_if;
   logic [3:0] req;
   logic [3:0] c;
   logic [1:0] sel;
   logic [3:0] gnt;
   logic       valid;
   logic       z;

   modport master (output req, c, input sel, gnt, valid, z);
   modport slave  (input req, c, output sel, gnt, valid, z);
endinterface

// File: rtl/mux4_rr_sched.sv
// Round-robin owner of a shared 4:1 bit mux, with a hold limit for fairness under contention.
// Latency: req to gnt is 1 cycle; no backpressure, so a requester waits by holding req high.
module mux4_rr_sched #(
   parameter int HOLD_MAX = 8
) (
   input logic            clk,
   input logic            reset,
   mux4_rr_sched_if.slave bus
);
   typedef enum logic {IDLE, OWN} state_t;

   localparam logic [7:0] CNT_LAST = 8'(HOLD_MAX - 1);

   state_t     state_q, state_d;
   logic [1:0] sel_q, sel_d;
   logic [3:0] gnt_q, gnt_d;
   logic       valid_q, valid_d;
   logic [1:0] ptr_q, ptr_d;
   logic [7:0] cnt_q, cnt_d;
   logic [2:0] pick;
   logic [1:0] nxt;

   // Returns {hit, index} of the first set bit at or after start, wrapping mod 4.
   function automatic logic [2:0] rr_pick(input logic [1:0] start, input logic [3:0] mask);
      logic [2:0] r;
      logic [1:0] idx;
      r = 3'b000;
      for (int k = 3; k >= 0; k--) begin
         idx = start + 2'(k);
         if (mask[idx]) r = {1'b1, idx};
      end
      return r;
   endfunction

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      gnt_d   = gnt_q;
      valid_d = valid_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      pick    = 3'b000;
      nxt     = sel_q + 2'd1;
      case (state_q)
         IDLE: begin
            gnt_d   = 4'b0000;
            valid_d = 1'b0;
            if (|bus.req) begin
               pick    = rr_pick(ptr_q, bus.req);
               sel_d   = pick[1:0];
               gnt_d   = 4'b0001 << pick[1:0];
               valid_d = 1'b1;
               cnt_d   = 8'd0;
               state_d = OWN;
            end
         end
         OWN: begin
            if (!bus.req[sel_q]) begin
               ptr_d = nxt;
               pick  = rr_pick(nxt, bus.req);
               cnt_d = 8'd0;
               if (pick[2]) begin
                  sel_d = pick[1:0];
                  gnt_d = 4'b0001 << pick[1:0];
               end else begin
                  gnt_d   = 4'b0000;
                  valid_d = 1'b0;
                  state_d = IDLE;
               end
            end else if (cnt_q == CNT_LAST) begin
               // Only hand over if someone else is actually waiting.
               pick  = rr_pick(nxt, bus.req & ~gnt_q);
               cnt_d = 8'd0;
               if (pick[2]) begin
                  sel_d = pick[1:0];
                  gnt_d = 4'b0001 << pick[1:0];
                  ptr_d = nxt;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         sel_q   <= 2'd0;
         gnt_q   <= 4'b0000;
         valid_q <= 1'b0;
         ptr_q   <= 2'd0;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         gnt_q   <= gnt_d;
         valid_q <= valid_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.sel   = sel_q;
   assign bus.gnt   = gnt_q;
   assign bus.valid = valid_q;
   assign bus.z     = valid_q & bus.c[sel_q];
endmodule

// File: tb/tb_mux4_rr_sched.sv
// Two schedulers (hold limits 8 and 1) on shared stimulus, checked every cycle against an ownership model.
module tb_mux4_rr_sched;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] req = 4'b0000;
   logic [3:0] c = 4'b0000;

   int checks = 0;
   int errors = 0;

   mux4_rr_sched_if bus0();
   mux4_rr_sched_if bus1();

   assign bus0.req = req;
   assign bus0.c   = c;
   assign bus1.req = req;
   assign bus1.c   = c;

   mux4_rr_sched #(.HOLD_MAX(8)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
   mux4_rr_sched #(.HOLD_MAX(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

   always #5 clk = ~clk;

   logic [1:0] sel_o[2];
   logic [3:0] gnt_o[2];
   logic       valid_o[2];
   logic       z_o[2];
   assign sel_o[0] = bus0.sel;   assign sel_o[1] = bus1.sel;
   assign gnt_o[0] = bus0.gnt;   assign gnt_o[1] = bus1.gnt;
   assign valid_o[0] = bus0.valid; assign valid_o[1] = bus1.valid;
   assign z_o[0] = bus0.z;       assign z_o[1] = bus1.z;

   // Model: who owns the mux, how many cycles it has owned it, where the next idle search starts.
   int hold[2]    = '{8, 1};
   int m_owner[2] = '{-1, -1};
   int m_held[2]  = '{0, 0};
   int m_ptr[2]   = '{0, 0};
   int m_sel[2]   = '{0, 0};

   function automatic int first_from(int s, logic [3:0] m);
      for (int k = 0; k < 4; k++) begin
         int i = (s + k) % 4;
         if (m[i]) return i;
      end
      return -1;
   endfunction

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         int o, w;
         o = m_owner[d];
         if (reset) begin
            m_owner[d] = -1; m_held[d] = 0; m_ptr[d] = 0; m_sel[d] = 0;
         end else if (o < 0) begin
            w = first_from(m_ptr[d], req);
            if (w >= 0) begin m_owner[d] = w; m_sel[d] = w; m_held[d] = 1; end
         end else if (!req[o]) begin
            m_ptr[d] = (o + 1) % 4;
            w = first_from(o + 1, req);
            if (w >= 0) begin m_owner[d] = w; m_sel[d] = w; m_held[d] = 1; end
            else m_owner[d] = -1;
         end else if (m_held[d] >= hold[d]) begin
            logic [3:0] others;
            others = req;
            others[o] = 1'b0;
            w = first_from(o + 1, others);
            m_held[d] = 1;
            if (w >= 0) begin m_owner[d] = w; m_sel[d] = w; m_ptr[d] = (o + 1) % 4; end
         end else begin
            m_held[d]++;
         end
      end
   end

   always @(posedge clk) begin
      #1;
      for (int d = 0; d < 2; d++) begin
         int o;
         logic [3:0] cv;
         o = m_owner[d];
         cv = c;
         chk($sformatf("valid%0d", d), int'(valid_o[d]), (o >= 0) ? 1 : 0);
         chk($sformatf("gnt%0d", d), int'(gnt_o[d]), (o >= 0) ? (1 << o) : 0);
         chk($sformatf("sel%0d", d), int'(sel_o[d]), m_sel[d]);
         chk($sformatf("z%0d", d), int'(z_o[d]), (o >= 0) ? int'(cv[o]) : 0);
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   initial begin
      logic [3:0] cv;

      // Reset held with all requesting.
      reset = 1'b1; req = 4'b1111; c = 4'b1111;
      repeat (3) step();
      chk("rst_gnt", int'(bus0.gnt), 0);
      chk("rst_valid", int'(bus0.valid), 0);
      chk("rst_sel", int'(bus0.sel), 0);
      chk("rst_z", int'(bus0.z), 0);
      reset = 1'b0;
      step();
      chk("first_gnt", int'(bus0.gnt), 1);
      chk("first_sel", int'(bus0.sel), 0);

      // Full contention: hold 8 rotates every 8 cycles, hold 1 every cycle.
      for (int t = 1; t < 40; t++) begin
         step();
         chk("rot8_gnt", int'(bus0.gnt), 1 << ((t / 8) % 4));
         chk("rot8_model", m_owner[0], (t / 8) % 4);
         chk("rot1_gnt", int'(bus1.gnt), 1 << (t % 4));
      end

      // Single requester is never preempted.
      reset = 1'b1; step();
      reset = 1'b0; req = 4'b0100; c = 4'b0100;
      step();
      chk("single_gnt", int'(bus0.gnt), 4);
      chk("single_sel", int'(bus0.sel), 2);
      chk("single_z", int'(bus0.z), 1);
      repeat (20) begin
         step();
         chk("single_hold", int'(bus0.gnt), 4);
      end
      req = 4'b0000;
      step();
      chk("single_idle", int'(bus0.valid), 0);
      chk("single_idle_z", int'(bus0.z), 0);
      chk("single_idle_sel", int'(bus0.sel), 2);

      // Early release hands over with no gap; ptr wraps 3 -> 0.
      reset = 1'b1; step();
      reset = 1'b0; req = 4'b0010; c = 4'b1010;
      step();
      chk("early_own1", int'(bus0.gnt), 2);
      req = 4'b1010;
      repeat (3) step();
      chk("early_still1", int'(bus0.gnt), 2);
      req = 4'b1000;
      step();
      chk("early_gnt3", int'(bus0.gnt), 8);
      chk("early_nogap", int'(bus0.valid), 1);
      req = 4'b0000;
      step();
      chk("early_idle", int'(bus0.valid), 0);
      req = 4'b0011;
      step();
      chk("early_wrap", int'(bus0.gnt), 1);

      // Hold 1 alternation between 0 and 3, z following the owner's data bit.
      reset = 1'b1; step();
      reset = 1'b0; req = 4'b1001;
      for (int t = 0; t < 10; t++) begin
         c = 4'($urandom);
         cv = c;
         step();
         chk("alt_gnt", int'(bus1.gnt), (t % 2 == 0) ? 1 : 8);
         chk("alt_z", int'(bus1.z), (t % 2 == 0) ? int'(cv[0]) : int'(cv[3]));
      end

      // Reset in the middle of a grant.
      reset = 1'b1; step();
      reset = 1'b0; req = 4'b0100; c = 4'b1111;
      step();
      repeat (5) step();
      chk("mid_own2", int'(bus0.gnt), 4);
      reset = 1'b1;
      step();
      chk("mid_rst_gnt", int'(bus0.gnt), 0);
      chk("mid_rst_valid", int'(bus0.valid), 0);
      chk("mid_rst_sel", int'(bus0.sel), 0);
      chk("mid_rst_z", int'(bus0.z), 0);
      reset = 1'b0; req = 4'b0110;
      step();
      chk("mid_regrant", int'(bus0.gnt), 2);

      // Random traffic with occasional resets.
      for (int t = 0; t < 3000; t++) begin
         reset = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 3) == 0) req = 4'($urandom);
         c = 4'($urandom);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
